// File: rtl/vx_mem_narrow_pkg.sv
// Shared types and geometry helpers for the line-to-beat memory narrower.
package vx_mem_narrow_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_e;

  // Beats per line.
  function automatic int nb(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  // Counter width: one extra bit so the count can reach nb() without wrapping.
  function automatic int cnt_w(input int line_w, input int beat_w);
    return $clog2(line_w / beat_w) + 1;
  endfunction

endpackage

// File: rtl/vx_mem_narrow_buf.sv
// Read-reassembly line buffer: NB slices of BEAT_W, one slice written per beat.
module vx_mem_narrow_buf #(
  parameter int NB     = 4,
  parameter int BEAT_W = 128,
  parameter int LB     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [LB-1:0]              wr_idx,
  input  logic [BEAT_W-1:0]          wr_data,
  output logic [NB-1:0][BEAT_W-1:0]  line
);

  for (genvar g = 0; g < NB; g++) begin : g_slice
    logic [BEAT_W-1:0] slice_q;

    // Capture the returned beat into its slot; cleared on reset so the line reads zero.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              slice_q <= '0;
      else if (wr_en && (wr_idx == LB'(g)))    slice_q <= wr_data;
    end

    assign line[g] = slice_q;
  end

endmodule

// File: rtl/vx_mem_narrow.sv
// Splits one full-line request into NB narrow beats and reassembles read beats.
// Optional build macro: VX_MEM_NARROW_SKIP_EN (write beats with all-zero byte
// enables are not issued; the issue counter jumps to the next enabled beat).
module vx_mem_narrow
  import vx_mem_narrow_pkg::*;
#(
  parameter int LINE_W = 512,
  parameter int BEAT_W = 128,
  parameter int ADDR_W = 26,
  parameter int TAG_W  = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      mem_req_valid,
  output logic                                      mem_req_ready,
  input  logic                                      mem_req_rw,
  input  logic [LINE_W/8-1:0]                       mem_req_byteen,
  input  logic [ADDR_W-1:0]                         mem_req_addr,
  input  logic [LINE_W-1:0]                         mem_req_data,
  input  logic [TAG_W-1:0]                          mem_req_tag,
  output logic                                      mem_rsp_valid,
  input  logic                                      mem_rsp_ready,
  output logic [LINE_W-1:0]                         mem_rsp_data,
  output logic [TAG_W-1:0]                          mem_rsp_tag,
  output logic                                      dn_req_valid,
  input  logic                                      dn_req_ready,
  output logic                                      dn_req_we,
  output logic [ADDR_W+cnt_w(LINE_W,BEAT_W)-2:0]    dn_req_addr,
  output logic [BEAT_W-1:0]                         dn_req_data,
  output logic [BEAT_W/8-1:0]                       dn_req_sel,
  input  logic                                      dn_rsp_valid,
  input  logic [BEAT_W-1:0]                         dn_rsp_data,
  output logic                                      busy,
  output logic                                      err
);

  localparam int NB = nb(LINE_W, BEAT_W);
  localparam int CW = cnt_w(LINE_W, BEAT_W);
  localparam int LB = CW - 1;
  localparam int SW = BEAT_W / 8;
  localparam logic [CW-1:0] NB_C   = CW'(NB);
  localparam logic [CW-1:0] LAST_C = CW'(NB - 1);

  state_e                     state;
  logic [CW-1:0]              iss_cnt, rcv_cnt;
  logic [ADDR_W-1:0]          addr_q;
  logic [TAG_W-1:0]           tag_q;
  logic [NB-1:0][BEAT_W-1:0]  data_q;
  logic [NB-1:0][SW-1:0]      ben_q;
  logic                       ready_q, rsp_vld_q, err_q;

  logic [LB-1:0]              iss_idx, rcv_idx;
  logic                       rsp_ok;
  logic [NB-1:0][BEAT_W-1:0]  buf_line;

  assign iss_idx = iss_cnt[LB-1:0];
  assign rcv_idx = rcv_cnt[LB-1:0];

  // A returned beat is only legal while reading and the line is not yet full.
  assign rsp_ok = dn_rsp_valid && (state == RD) && (rcv_cnt != NB_C);

`ifdef VX_MEM_NARROW_SKIP_EN
  logic          beat_zero;
  logic [CW-1:0] nxt_cnt;

  assign beat_zero = (ben_q[iss_idx] == '0);

  // Next beat at or after the current one with any byte enabled; NB if none remain.
  always_comb begin
    nxt_cnt = NB_C;
    for (int j = NB - 1; j >= 0; j--)
      if ((CW'(j) >= iss_cnt) && (ben_q[j] != '0)) nxt_cnt = CW'(j);
  end
`endif

  // Beat-side outputs are decoded from registered state and counters only.
  always_comb begin
    dn_req_valid = 1'b0;
    dn_req_we    = 1'b0;
    dn_req_sel   = '0;
    unique case (state)
      WR: begin
`ifdef VX_MEM_NARROW_SKIP_EN
        dn_req_valid = !beat_zero;
`else
        dn_req_valid = 1'b1;
`endif
        dn_req_we    = 1'b1;
        dn_req_sel   = ben_q[iss_idx];
      end
      RD: begin
        dn_req_valid = (iss_cnt != NB_C);
        dn_req_sel   = '1;
      end
      default: ;
    endcase
  end

  assign dn_req_addr   = {addr_q, iss_idx};
  assign dn_req_data   = data_q[iss_idx];
  assign mem_req_ready = ready_q;
  assign mem_rsp_valid = rsp_vld_q;
  assign mem_rsp_data  = buf_line;
  assign mem_rsp_tag   = tag_q;
  assign busy          = (state != IDLE);
  assign err           = err_q;

  // Control FSM: accept a line, issue/collect beats, hold the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      iss_cnt   <= '0;
      rcv_cnt   <= '0;
      addr_q    <= '0;
      tag_q     <= '0;
      data_q    <= '0;
      ben_q     <= '0;
      ready_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (dn_rsp_valid && !rsp_ok) err_q <= 1'b1;
      if (rsp_ok) rcv_cnt <= rcv_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (mem_req_valid && ready_q) begin
            addr_q  <= mem_req_addr;
            tag_q   <= mem_req_tag;
            data_q  <= mem_req_data;
            ben_q   <= mem_req_byteen;
            iss_cnt <= '0;
            rcv_cnt <= '0;
            ready_q <= 1'b0;
            state   <= mem_req_rw ? WR : RD;
          end else begin
            ready_q <= 1'b1;
          end
        end
        WR: begin
`ifdef VX_MEM_NARROW_SKIP_EN
          if (beat_zero) begin
            iss_cnt <= nxt_cnt;
            if (nxt_cnt == NB_C) begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end
          end else if (dn_req_ready) begin
            iss_cnt <= iss_cnt + 1'b1;
            if (iss_cnt == LAST_C) begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end
          end
`else
          if (dn_req_ready) begin
            iss_cnt <= iss_cnt + 1'b1;
            if (iss_cnt == LAST_C) begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end
          end
`endif
        end
        RD: begin
          if (dn_req_valid && dn_req_ready) iss_cnt <= iss_cnt + 1'b1;
          if (rsp_ok && (rcv_cnt == LAST_C)) begin
            state     <= RSP;
            rsp_vld_q <= 1'b1;
          end
        end
        RSP: begin
          if (mem_rsp_ready) begin
            rsp_vld_q <= 1'b0;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  vx_mem_narrow_buf #(.NB(NB), .BEAT_W(BEAT_W), .LB(LB)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rsp_ok),
    .wr_idx  (rcv_idx),
    .wr_data (dn_rsp_data),
    .line    (buf_line)
  );

endmodule

// File: tb/tb_vx_mem_narrow.sv
// Directed self-checking bench for vx_mem_narrow (NB=4, downstream read latency 3).
module tb_vx_mem_narrow;
  localparam int LINE_W = 512;
  localparam int BEAT_W = 128;
  localparam int ADDR_W = 26;
  localparam int TAG_W  = 8;
  localparam int OW = 1 + 1 + LINE_W + TAG_W + 1 + 1 + (ADDR_W + 2) + BEAT_W + BEAT_W/8 + 1 + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_req_valid = 1'b0, mem_req_ready, mem_req_rw = 1'b0;
  logic [LINE_W/8-1:0] mem_req_byteen = '0;
  logic [ADDR_W-1:0]   mem_req_addr = '0;
  logic [LINE_W-1:0]   mem_req_data = '0;
  logic [TAG_W-1:0]    mem_req_tag = '0;
  logic mem_rsp_valid, mem_rsp_ready = 1'b0;
  logic [LINE_W-1:0]   mem_rsp_data;
  logic [TAG_W-1:0]    mem_rsp_tag;
  logic dn_req_valid, dn_req_ready = 1'b1, dn_req_we;
  logic [ADDR_W+1:0]   dn_req_addr;
  logic [BEAT_W-1:0]   dn_req_data;
  logic [BEAT_W/8-1:0] dn_req_sel;
  logic dn_rsp_valid = 1'b0;
  logic [BEAT_W-1:0]   dn_rsp_data = '0;
  logic busy, err;

  int checks = 0;
  int failures = 0;

  logic [OW-1:0]     all_out;
  logic [LINE_W-1:0] wdata, rexp;
  logic [127:0]      wexp [4];
  logic              spur = 1'b0;
  logic [2:0]        pv = '0;
  logic [127:0]      pd [3];

  assign all_out = {mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag, dn_req_valid,
                    dn_req_we, dn_req_addr, dn_req_data, dn_req_sel, busy, err};

  vx_mem_narrow dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag),
    .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_we(dn_req_we),
    .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data), .dn_req_sel(dn_req_sel),
    .dn_rsp_valid(dn_rsp_valid), .dn_rsp_data(dn_rsp_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Downstream memory: a read beat accepted in cycle c returns {16{A0+idx}} in cycle c+3.
  always @(posedge clk) begin
    logic       hs;
    logic [1:0] idx;
    hs  = dn_req_valid && dn_req_ready && !dn_req_we;
    idx = dn_req_addr[1:0];
    #1;
    pv    = {pv[1:0], hs};
    pd[2] = pd[1];
    pd[1] = pd[0];
    pd[0] = {16{8'hA0 + {6'd0, idx}}};
    dn_rsp_valid = pv[2] | spur;
    dn_rsp_data  = pd[2];
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Present a request once ready is seen (called at a negedge, returns at next negedge).
  task automatic issue(input logic rw, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                       input logic [63:0] be, input logic [TAG_W-1:0] tg);
    int n = 0;
    while (!mem_req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (mem_req_ready !== 1'b1) begin
      failures++; $display("FAIL issue_ready got=%b exp=1", mem_req_ready);
    end
    mem_req_rw = rw; mem_req_addr = a; mem_req_data = d; mem_req_byteen = be; mem_req_tag = tg;
    mem_req_valid = 1'b1;
    @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req_ready, busy} !== 2'b10) begin
      failures++; $display("FAIL reset_release ready_busy=%b exp=10", {mem_req_ready, busy});
    end
  endtask

  task automatic test_write_full();
    dn_req_ready = 1'b1;
    issue(1'b1, 26'h400A, wdata, '1, 8'h00);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({dn_req_valid, dn_req_we, dn_req_addr, dn_req_data, dn_req_sel} !==
          {1'b1, 1'b1, 28'h10028 + 28'(k), wexp[k], 16'hFFFF}) begin
        failures++;
        $display("FAIL write_beat%0d v=%b we=%b addr=%h data=%h sel=%h exp addr=%h data=%h", k,
                 dn_req_valid, dn_req_we, dn_req_addr, dn_req_data, dn_req_sel,
                 28'h10028 + 28'(k), wexp[k]);
      end
      @(negedge clk);
    end
    checks++;
    if ({mem_req_ready, busy, dn_req_valid} !== 3'b100) begin
      failures++; $display("FAIL write_done ready_busy_valid=%b exp=100", {mem_req_ready, busy, dn_req_valid});
    end
  endtask

  task automatic test_read();
    mem_rsp_ready = 1'b0;
    issue(1'b0, 26'h400A, '0, '0, 8'h5A);
    checks++;
    if ({dn_req_valid, dn_req_we, dn_req_addr, dn_req_sel} !== {1'b1, 1'b0, 28'h10028, 16'hFFFF}) begin
      failures++; $display("FAIL read_beat0 v=%b we=%b addr=%h sel=%h exp 1 0 10028 ffff",
                           dn_req_valid, dn_req_we, dn_req_addr, dn_req_sel);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (mem_rsp_valid !== 1'b0) begin failures++; $display("FAIL read_early got=%b exp=0", mem_rsp_valid); end
    @(negedge clk);
    checks++;
    if ({mem_rsp_valid, mem_rsp_tag, mem_rsp_data} !== {1'b1, 8'h5A, rexp}) begin
      failures++; $display("FAIL read_rsp v=%b tag=%h data=%h exp tag=5a data=%h",
                           mem_rsp_valid, mem_rsp_tag, mem_rsp_data, rexp);
    end
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    mem_rsp_ready = 1'b0;
    checks++;
    if ({mem_rsp_valid, mem_req_ready} !== 2'b01) begin
      failures++; $display("FAIL read_done valid_ready=%b exp=01", {mem_rsp_valid, mem_req_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W+1:0]   p_addr;
    logic [BEAT_W-1:0]   p_data;
    logic [BEAT_W/8-1:0] p_sel;
    logic stalled = 1'b0;
    int   nacc = 0;
    int   c = 0;
    issue(1'b1, 26'h400A, wdata, '1, 8'h00);
    while (busy && c < 40) begin
      dn_req_ready = (c % 4 == 0) || (c % 4 == 3);
      if (dn_req_valid) begin
        if (stalled) begin
          checks++;
          if ({dn_req_addr, dn_req_data, dn_req_sel} !== {p_addr, p_data, p_sel}) begin
            failures++; $display("FAIL bp_stable addr=%h data=%h exp addr=%h data=%h",
                                 dn_req_addr, dn_req_data, p_addr, p_data);
          end
        end
        if (dn_req_ready && nacc < 4) begin
          checks++;
          if ({dn_req_addr, dn_req_data} !== {28'h10028 + 28'(nacc), wexp[nacc]}) begin
            failures++; $display("FAIL bp_beat%0d addr=%h data=%h exp addr=%h data=%h", nacc,
                                 dn_req_addr, dn_req_data, 28'h10028 + 28'(nacc), wexp[nacc]);
          end
          nacc++;
        end
      end
      p_addr = dn_req_addr; p_data = dn_req_data; p_sel = dn_req_sel;
      stalled = dn_req_valid && !dn_req_ready;
      c++;
      @(negedge clk);
    end
    dn_req_ready = 1'b1;
    checks++;
    if ({busy, 32'(nacc)} !== {1'b0, 32'd4}) begin
      failures++; $display("FAIL bp_count beats=%0d busy=%b exp beats=4 busy=0", nacc, busy);
    end
    mem_rsp_ready = 1'b0;
    issue(1'b0, 26'h0123, '0, '0, 8'hC3);
    c = 0;
    while (!mem_rsp_valid && c < 30) begin @(negedge clk); c++; end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({mem_rsp_valid, mem_rsp_tag, mem_rsp_data} !== {1'b1, 8'hC3, rexp}) begin
        failures++; $display("FAIL bp_rsp_hold%0d v=%b tag=%h data=%h exp tag=c3 data=%h", k,
                             mem_rsp_valid, mem_rsp_tag, mem_rsp_data, rexp);
      end
      @(negedge clk);
    end
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    mem_rsp_ready = 1'b0;
    checks++;
    if ({mem_rsp_valid, mem_req_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_rsp_release valid_ready=%b exp=01", {mem_rsp_valid, mem_req_ready});
    end
  endtask

  task automatic test_spurious();
    int c = 0;
    spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL spur_err got=%b exp=1", err); end
    mem_rsp_ready = 1'b1;
    issue(1'b0, 26'h2000, '0, '0, 8'h77);
    while (!mem_rsp_valid && c < 30) begin @(negedge clk); c++; end
    checks++;
    if ({mem_rsp_valid, err, mem_rsp_tag, mem_rsp_data} !== {1'b1, 1'b1, 8'h77, rexp}) begin
      failures++; $display("FAIL spur_read v=%b err=%b tag=%h data=%h exp 1 1 77 %h",
                           mem_rsp_valid, err, mem_rsp_tag, mem_rsp_data, rexp);
    end
    @(negedge clk);
    mem_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c = 0;
    dn_req_ready = 1'b1;
    issue(1'b1, 26'h400A, wdata, '1, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (dn_req_addr !== 28'h1002A) begin failures++; $display("FAIL rst_mid_pos addr=%h exp=1002a", dn_req_addr); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL rst_mid_outputs got=%h exp=0", all_out); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req_ready, busy} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_release ready_busy=%b exp=10", {mem_req_ready, busy});
    end
    mem_rsp_ready = 1'b1;
    issue(1'b0, 26'h400A, '0, '0, 8'h21);
    while (!mem_rsp_valid && c < 30) begin @(negedge clk); c++; end
    checks++;
    if ({mem_rsp_valid, err, mem_rsp_tag, mem_rsp_data} !== {1'b1, 1'b0, 8'h21, rexp}) begin
      failures++; $display("FAIL rst_mid_read v=%b err=%b tag=%h data=%h exp 1 0 21 %h",
                           mem_rsp_valid, err, mem_rsp_tag, mem_rsp_data, rexp);
    end
    @(negedge clk);
    mem_rsp_ready = 1'b0;
  endtask

  task automatic test_zero_sel();
    int n = 0;
    logic [15:0] sels [4];
    logic [ADDR_W+1:0] last_addr = '0;
    dn_req_ready = 1'b1;
    issue(1'b1, 26'h400A, wdata, 64'h0000FFFF_00000000, 8'h00);
`ifdef VX_MEM_NARROW_SKIP_EN
    for (int k = 0; k < 3; k++) begin
      if (dn_req_valid) begin n++; last_addr = dn_req_addr; end
      @(negedge clk);
    end
    checks++;
    if ({32'(n), last_addr} !== {32'd1, 28'h1002A}) begin
      failures++; $display("FAIL skip_beats n=%0d addr=%h exp n=1 addr=1002a", n, last_addr);
    end
    checks++;
    if ({mem_req_ready, busy} !== 2'b10) begin
      failures++; $display("FAIL skip_idle ready_busy=%b exp=10", {mem_req_ready, busy});
    end
`else
    for (int k = 0; k < 4; k++) begin
      sels[k] = dn_req_sel;
      if (dn_req_valid) n++;
      @(negedge clk);
    end
    checks++;
    if ({32'(n), sels[0], sels[1], sels[2], sels[3]} !== {32'd4, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000}) begin
      failures++; $display("FAIL zero_sel n=%0d sels=%h %h %h %h exp 4 0000 0000 ffff 0000",
                           n, sels[0], sels[1], sels[2], sels[3]);
    end
    checks++;
    if ({mem_req_ready, busy} !== 2'b10) begin
      failures++; $display("FAIL zero_sel_idle ready_busy=%b exp=10", {mem_req_ready, busy});
    end
`endif
  endtask

  task automatic test_back_to_back();
    int c = 0;
    mem_rsp_ready = 1'b1;
    issue(1'b1, 26'h0042, wdata, '1, 8'h00);
    issue(1'b0, 26'h0042, '0, '0, 8'h9E);
    while (!mem_rsp_valid && c < 30) begin @(negedge clk); c++; end
    checks++;
    if ({mem_rsp_valid, mem_rsp_tag, mem_rsp_data} !== {1'b1, 8'h9E, rexp}) begin
      failures++; $display("FAIL b2b_read v=%b tag=%h data=%h exp tag=9e data=%h",
                           mem_rsp_valid, mem_rsp_tag, mem_rsp_data, rexp);
    end
    @(negedge clk);
    mem_rsp_ready = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 15; k++) wdata[32*(15-k) +: 32] = 32'(32'h11111111 * (k + 1));
    wdata[31:0] = 32'h12345678;
    wexp[0] = 128'hDDDDDDDD_EEEEEEEE_FFFFFFFF_12345678;
    wexp[1] = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    wexp[2] = 128'h55555555_66666666_77777777_88888888;
    wexp[3] = 128'h11111111_22222222_33333333_44444444;
    rexp = {{16{8'hA3}}, {16{8'hA2}}, {16{8'hA1}}, {16{8'hA0}}};
    for (int k = 0; k < 3; k++) pd[k] = '0;

    test_reset();
    test_write_full();
    test_read();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    test_zero_sel();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_mem_narrow.md
# vx_mem_narrow

Downstream neighbour of the Vortex core's memory port. It accepts one full-line request (512-bit data, 64-bit byte enable, line address, tag) from `Vortex` and splits it into a burst of narrower beats on the board memory port. For reads, it reassembles the returned beats into a line and returns that line to the core with the original tag. Only one line is in flight at a time.

## Interface
Parameters:
- `LINE_W`, 512: line width; equals `VX_MEM_DATA_WIDTH`.
- `BEAT_W`, 128: downstream beat width. `LINE_W/BEAT_W` = `NB` must be a power of two, ≥2.
- `ADDR_W`, 26: line address width; equals `VX_MEM_ADDR_WIDTH`.
- `TAG_W`, 8: tag width; equals `VX_MEM_TAG_WIDTH`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: **asynchronous, active-low** reset.
- `mem_req_valid` / `mem_req_ready` in/out 1: upstream request handshake.
- `mem_req_rw` in 1: 1 = write, 0 = read.
- `mem_req_byteen` in `LINE_W/8`, `mem_req_addr` in `ADDR_W`, `mem_req_data` in `LINE_W`, `mem_req_tag` in `TAG_W`: request fields.
- `mem_rsp_valid` / `mem_rsp_ready` out/in 1: upstream read-response handshake.
- `mem_rsp_data` out `LINE_W`, `mem_rsp_tag` out `TAG_W`: response fields.
- `dn_req_valid` / `dn_req_ready` out/in 1: downstream beat handshake.
- `dn_req_we` out 1: write enable for the beat.
- `dn_req_addr` out `ADDR_W+log2(NB)`: beat address, `{line_addr, beat_idx}`.
- `dn_req_data` out `BEAT_W`, `dn_req_sel` out `BEAT_W/8`: beat data and byte select.
- `dn_rsp_valid` in 1, `dn_rsp_data` in `BEAT_W`: read beats. They return in issue order and have no backpressure.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky flag for an unexpected `dn_rsp_valid`.

## Operation
- FSM states: IDLE, WR, RD, RSP.
- IDLE:
  - `mem_req_ready`=1 only in IDLE.
  - On accept, latch addr, tag, rw, data and byteen, and clear `iss_cnt` and `rcv_cnt`.
  - Go to WR if `rw`=1, otherwise RD.
- Beat i carries line bits `[i*BEAT_W +: BEAT_W]` and byteen bits `[i*BEAT_W/8 +: BEAT_W/8]`. Beat 0 is the least-significant slice.
- WR:
  - `dn_req_valid`=1, `we`=1, beat `iss_cnt`.
  - `iss_cnt` increments on each `dn_req_valid & dn_req_ready`.
  - After beat `NB-1` is accepted, go to IDLE. Writes generate no upstream response.
- RD:
  - `dn_req_valid`=1, `we`=0, `sel` all ones, while `iss_cnt<NB`.
  - Each `dn_rsp_valid` writes `dn_rsp_data` into buffer slice `rcv_cnt`, then `rcv_cnt++`.
  - Issue and receive run concurrently; a response may arrive in the same cycle as an issue.
  - When `rcv_cnt` reaches `NB`, go to RSP.
- RSP:
  - `mem_rsp_valid`=1 with the buffer contents and the latched tag. Both are held stable until `mem_rsp_ready`.
  - On `mem_rsp_ready`, go to IDLE.
- Boundaries:
  - `iss_cnt` and `rcv_cnt` are `log2(NB)+1` bits wide and never wrap.
  - `dn_req_valid` stays low once `iss_cnt`=NB.
  - `dn_rsp_valid` in IDLE, WR or RSP, or when `rcv_cnt`=NB: data is dropped and `err` sets. `err` is cleared only by reset.
  - The line address passes through unmodified; the beat index occupies the LSBs.
- Reset:
  - Asserting reset at any time, including mid-burst, forces IDLE and aborts the in-flight line.
  - All outputs go low and the counters clear. Buffer contents are don't-care.

## Timing
- Accept in cycle t: first beat is valid at t+1. Outputs are registered-state driven.
- Write with `dn_req_ready` always high: beats at t+1..t+NB. IDLE and `mem_req_ready`=1 at t+NB+1.
- Read with fixed downstream latency L (response L cycles after beat acceptance): last beat arrives at t+NB+L, and `mem_rsp_valid` is high at t+NB+L+1.
- `dn_req_ready` low stalls `iss_cnt`. The beat's fields are held stable while stalled.
- Back-to-back requests: minimum gap of 1 IDLE cycle between lines.

## Configuration
- `VX_MEM_NARROW_SKIP_EN` defined:
  - In WR, a beat whose byteen slice is all zero is not issued. `iss_cnt` advances past it in the same cycle without asserting `dn_req_valid`.
  - A write whose byteen is all zero goes from WR to IDLE in one cycle.
- Undefined: every beat is issued, including those with `sel`=0.
- Reads are unaffected either way.

## Structure
- Shared package `vx_mem_narrow_pkg`:
  - State enum `state_e` (IDLE, WR, RD, RSP).
  - Functions `nb()` and `cnt_w()` derived from `LINE_W` and `BEAT_W`.
- Sub-module `vx_mem_narrow_buf`: `NB`×`BEAT_W` line buffer. It has a write-slice port and presents the full line output. Beat selection from the latched request is done in the top level.

## Test plan
The bench uses the defaults: `NB`=4, beat address = line×4+i.
- **Write, full byteen:**
  - Stimulus: line 0x400A, data with 32-bit words 0x11111111…0x12345678, MS word first.
  - Expect beat addresses 0x10028..0x1002B.
  - Expect beat0 = 0xDDDDDDDD_EEEEEEEE_FFFFFFFF_12345678, `sel`=0xFFFF.
  - Expect `mem_req_ready` high again 5 cycles after accept.
- **Read, fixed latency:**
  - Stimulus: line 0x400A, tag 0x5A, `dn_req_ready`=1, L=3. Downstream returns 0xA0.., 0xA1.., 0xA2.., 0xA3..
  - Expect `mem_rsp_data` = {A3,A2,A1,A0} and tag 0x5A at t+8.
- **Backpressure:**
  - Stimulus: `dn_req_ready` toggles 1,0,0,1… during a write; `mem_rsp_ready` held low 5 cycles during a read.
  - Expect beat fields stable while stalled and no beat duplicated or lost.
  - Expect the response held unchanged until `mem_rsp_ready`.
- **Spurious response:**
  - Stimulus: `dn_rsp_valid` pulse while IDLE.
  - Expect `err`=1 and `err` to remain 1 through a subsequent read. That read returns correct data.
- **Reset mid-burst:**
  - Stimulus: assert reset after 2 write beats.
  - Expect all outputs 0 asynchronously and `mem_req_ready`=1 after release.
  - Expect the next read to complete normally.
- **Skip (`VX_MEM_NARROW_SKIP_EN`):**
  - Stimulus: byteen = 0x0000FFFF_00000000.
  - Expect only beat 2 issued, address 0x1002A.
  - Expect IDLE 4 cycles after accept.
